// File: rtl/memory_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, port ids, wait-counter width.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  localparam int WAITCNT_W = 4;

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational winner select: D beats I unless I has lost maxWait times in a row.
// A masked port is ignored entirely, so a lone unmasked requester always wins.
module memory_arbiter_pick
  import memory_arbiter_pkg::*;
(
  input  logic                 iReq,
  input  logic                 dReq,
  input  logic [1:0]           mask,
  input  logic [WAITCNT_W-1:0] waitCnt,
  input  logic [WAITCNT_W-1:0] maxWait,
  output logic                 valid,
  output port_t                port
);

  logic iLive;
  logic dLive;

  always_comb begin
    iLive = iReq & ~mask[PORT_I];
    dLive = dReq & ~mask[PORT_D];
    valid = iLive | dLive;
    port  = (iLive && (!dLive || (waitCnt >= maxWait))) ? PORT_I : PORT_D;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Sequences the core's I (read-only) and D ports onto one single-port memory, one access at a time.
// Ack 2 cycles after an uncontended request; requesters hold req until ack, out-of-range accesses are suppressed.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int width   = 64,
  parameter int depth   = 8,
  parameter int maxWait = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iReq,
  input  logic [width-1:0] iAddr,
  output logic             iAck,
  output logic [width-1:0] iData,
  input  logic             dReq,
  input  logic             dWr,
  input  logic [width-1:0] dAddr,
  input  logic [width-1:0] dWdata,
  output logic             dAck,
  output logic [width-1:0] dData,
  output logic             err,
  output logic [width-1:0] address,
  output logic [width-1:0] dataWri,
  output logic             memoryWri,
  output logic             memoryRead,
  input  logic [width-1:0] dataRead
);

  localparam logic [WAITCNT_W-1:0] MAX_WAIT = WAITCNT_W'(maxWait);

  arb_state_t           state;
  arb_state_t           stateNxt;
  port_t                latPort;
  logic [width-1:0]     latAddr;
  logic [width-1:0]     latWdata;
  logic                 latWr;
  logic [WAITCNT_W-1:0] waitCnt;
  logic                 arbEn;
  logic [1:0]           mask;
  logic                 pickVld;
  port_t                pickPort;
  logic                 inRange;
  logic                 iLive;

  assign inRange = (latAddr >> depth) == '0;
  // The port acked this cycle must not be re-sampled, so it is masked out of arbitration.
  assign iLive   = iReq & ~mask[PORT_I];

  memory_arbiter_pick u_pick (
    .iReq    (iReq),
    .dReq    (dReq),
    .mask    (mask),
    .waitCnt (waitCnt),
    .maxWait (MAX_WAIT),
    .valid   (pickVld),
    .port    (pickPort)
  );

  always_comb begin
    stateNxt   = state;
    arbEn      = 1'b0;
    mask       = 2'b00;
    address    = '0;
    dataWri    = '0;
    memoryWri  = 1'b0;
    memoryRead = 1'b0;
    case (state)
      IDLE: begin
        arbEn = 1'b1;
        if (pickVld) stateNxt = ACCESS;
      end
      ACCESS: begin
        address    = latAddr;
        dataWri    = latWdata;
        memoryRead = ~latWr & inRange;
        memoryWri  = latWr & inRange & ~reset;
        stateNxt   = RESP;
      end
      RESP: begin
        arbEn    = 1'b1;
        mask     = (latPort == PORT_I) ? 2'b01 : 2'b10;
        stateNxt = pickVld ? ACCESS : IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      latPort  <= PORT_I;
      latAddr  <= '0;
      latWdata <= '0;
      latWr    <= 1'b0;
      waitCnt  <= '0;
      iAck     <= 1'b0;
      dAck     <= 1'b0;
      err      <= 1'b0;
      iData    <= '0;
      dData    <= '0;
    end else begin
      state <= stateNxt;
      iAck  <= (state == ACCESS) && (latPort == PORT_I);
      dAck  <= (state == ACCESS) && (latPort == PORT_D);
      if (state == ACCESS) begin
        err <= ~inRange;
        if (latPort == PORT_I) begin
          iData <= inRange ? dataRead : '0;
        end else if (!latWr) begin
          dData <= inRange ? dataRead : '0;
        end
      end
      if (arbEn) begin
        if (pickVld) begin
          latPort  <= pickPort;
          latAddr  <= (pickPort == PORT_I) ? iAddr : dAddr;
          latWr    <= (pickPort == PORT_D) & dWr;
          latWdata <= (pickPort == PORT_D) ? dWdata : '0;
        end
        if (!iLive || (pickVld && pickPort == PORT_I)) begin
          waitCnt <= '0;
        end else if (waitCnt != '1) begin
          waitCnt <= waitCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized I/D traffic against a transaction-level model.
module tb_memory_arbiter;

  localparam int W    = 64;
  localparam int D    = 8;
  localparam int MAXW = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         iReq = 1'b0;
  logic [W-1:0] iAddr = '0;
  logic         iAck;
  logic [W-1:0] iData;
  logic         dReq = 1'b0;
  logic         dWr = 1'b0;
  logic [W-1:0] dAddr = '0;
  logic [W-1:0] dWdata = '0;
  logic         dAck;
  logic [W-1:0] dData;
  logic         err;
  logic [W-1:0] address;
  logic [W-1:0] dataWri;
  logic         memoryWri;
  logic         memoryRead;
  logic [W-1:0] dataRead;

  always #5 clk = ~clk;

  memory_arbiter #(.width(W), .depth(D), .maxWait(MAXW)) dut (
    .clk        (clk),
    .reset      (reset),
    .iReq       (iReq),
    .iAddr      (iAddr),
    .iAck       (iAck),
    .iData      (iData),
    .dReq       (dReq),
    .dWr        (dWr),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .dAck       (dAck),
    .dData      (dData),
    .err        (err),
    .address    (address),
    .dataWri    (dataWri),
    .memoryWri  (memoryWri),
    .memoryRead (memoryRead),
    .dataRead   (dataRead)
  );

  function automatic logic [63:0] init_val(int i);
    case (i)
      0:       return 64'h0BAD;
      5:       return 64'hA5;
      7:       return 64'h7777;
      default: return 64'hC0DE_0000_0000_0000 | 64'(i);
    endcase
  endfunction

  // Memory seen by the DUT: combinational read, write on the rising edge.
  logic [W-1:0] mem [0:255];
  assign dataRead = mem[address[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (memoryWri) mem[address[7:0]] = dataWri;
    end
  end

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_iack = 0;
  int n_dack = 0;
  int n_wri = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (iAck) n_iack++;
    if (dAck) n_dack++;
    if (memoryWri) n_wri++;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one access in flight, scheduled to complete 2 cycles after its grant.
  // Grants happen when nothing is in flight or in the completion cycle (with the completing port excluded).
  initial begin
    logic [63:0] refmem [0:255];
    bit          pend = 1'b0;
    bit          who = 1'b0;
    int          due = 0;
    logic [63:0] paddr = '0;
    logic [63:0] pwd = '0;
    bit          pwr = 1'b0;
    logic [63:0] pres = '0;
    logic [63:0] e_idata = '0;
    logic [63:0] e_ddata = '0;
    bit          e_err = 1'b0;
    int          wc = 0;
    bit          ack_now, acc_now, inr, ei, ed, gi;
    for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ack_now = pend && (due == cyc);
        acc_now = pend && (due == cyc + 1);
        inr     = (paddr >> D) == 0;
        if (ack_now) begin
          if (!who) e_idata = pres;
          else if (!pwr) e_ddata = pres;
          e_err = !inr;
        end
        chk("iAck", 64'(iAck), 64'(ack_now && !who));
        chk("dAck", 64'(dAck), 64'(ack_now && who));
        if (ack_now) chk("err", 64'(err), 64'(e_err));
        chk("iData", iData, e_idata);
        chk("dData", dData, e_ddata);
        chk("memoryRead", 64'(memoryRead), 64'(acc_now && !pwr && inr));
        chk("memoryWri", 64'(memoryWri), 64'(acc_now && pwr && inr && !reset));
        chk("address", address, acc_now ? paddr : 64'd0);
        chk("dataWri", dataWri, acc_now ? pwd : 64'd0);
        if (reset) begin
          pend = 1'b0; wc = 0; e_idata = '0; e_ddata = '0; e_err = 1'b0;
        end else begin
          if (acc_now) begin
            if (pwr && inr) refmem[paddr[7:0]] = pwd;
            pres = (!pwr && inr) ? refmem[paddr[7:0]] : 64'd0;
          end
          if (!pend || ack_now) begin
            ei = iReq && !(ack_now && !who);
            ed = dReq && !(ack_now && who);
            if (ei || ed) begin
              gi    = ei && (!ed || wc >= MAXW);
              who   = !gi;
              paddr = gi ? iAddr : dAddr;
              pwr   = gi ? 1'b0 : dWr;
              pwd   = gi ? 64'd0 : dWdata;
              pend  = 1'b1;
              due   = cyc + 2;
              wc    = gi ? 0 : (ei ? ((wc < 15) ? wc + 1 : 15) : 0);
            end else begin
              pend = 1'b0;
              wc   = 0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit isD, input string nm, output int c);
    c = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (isD ? dAck : iAck) begin
        c = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no ack within 64 cycles (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 64'd256 + 64'($urandom_range(0, 4000));
    return 64'($urandom_range(0, 255));
  endfunction

  task automatic drv_i(int n);
    int c;
    for (int t = 0; t < n; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        iReq = 1'b0;
        repeat (gap) tick();
      end
      iReq  = 1'b1;
      iAddr = rand_addr();
      wait_ack(1'b0, "rand_i_ack", c);
      tick();
    end
    iReq = 1'b0;
  endtask

  task automatic drv_d(int n);
    int c;
    for (int t = 0; t < n; t++) begin
      int gap;
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      if (gap > 0) begin
        dReq = 1'b0;
        repeat (gap) tick();
      end
      dReq   = 1'b1;
      dWr    = 1'($urandom_range(0, 1));
      dAddr  = rand_addr();
      dWdata = {$urandom, $urandom};
      wait_ack(1'b1, "rand_d_ack", c);
      tick();
    end
    dReq = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, c, td, ti, nd, d0, w0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_iAck", 64'(iAck), 0);
    chk("rst_dAck", 64'(dAck), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_iData", iData, 0);
    chk("rst_dData", dData, 0);
    chk("rst_address", address, 0);
    chk("rst_memoryRead", 64'(memoryRead), 0);

    // I-only read of preloaded word.
    d0 = n_dack;
    tick();
    iReq = 1'b1; iAddr = 64'd5; k = cyc;
    wait_ack(1'b0, "t1_ack", c);
    chk("t1_latency", 64'(c - k), 2);
    chk("t1_iData", iData, 64'hA5);
    chk("t1_err", 64'(err), 0);
    tick(); iReq = 1'b0;
    tick();
    chk("t1_no_dack", 64'(n_dack - d0), 0);

    // D write then read back the same word.
    dReq = 1'b1; dWr = 1'b1; dAddr = 64'd3; dWdata = 64'h1234;
    wait_ack(1'b1, "t2_wr_ack", c);
    chk("t2_wr_err", 64'(err), 0);
    tick(); dWr = 1'b0; k = cyc;
    wait_ack(1'b1, "t2_rd_ack", c);
    chk("t2_rd_latency", 64'(c - k), 2);
    chk("t2_dData", dData, 64'h1234);
    chk("t2_iData_held", iData, 64'hA5);
    tick(); dReq = 1'b0;
    tick();

    // Simultaneous requests from IDLE: D first, I exactly 2 cycles later.
    iReq = 1'b1; iAddr = 64'd5; dReq = 1'b1; dWr = 1'b0; dAddr = 64'd3; k = cyc;
    td = -1; ti = -1;
    for (int n = 0; n < 64 && (td < 0 || ti < 0); n++) begin
      @(negedge clk);
      if (dAck && td < 0) td = cyc;
      if (iAck && ti < 0) ti = cyc;
      tick();
      if (td >= 0) dReq = 1'b0;
      if (ti >= 0) iReq = 1'b0;
    end
    chk("t3_d_first", 64'(td - k), 2);
    chk("t3_i_gap", 64'(ti - td), 2);
    tick();

    // D never lets go while I waits: I must still be served within maxWait D accesses.
    iReq = 1'b1; iAddr = 64'd9; dReq = 1'b1; dWr = 1'b0; dAddr = 64'd4;
    nd = 0; ti = -1;
    for (int n = 0; n < 64 && ti < 0; n++) begin
      @(negedge clk);
      if (dAck) nd++;
      if (iAck) ti = cyc;
      tick();
      if (dAck) dAddr = dAddr + 64'd1;
      if (ti >= 0) iReq = 1'b0;
    end
    chk("t4_i_granted", 64'(ti >= 0), 1);
    chk("t4_dacks_bounded", 64'(nd >= 1 && nd <= MAXW), 1);
    chk("t4_iData", iData, init_val(9));
    wait_ack(1'b1, "t4_d_drain", c);
    tick(); dReq = 1'b0;
    tick();

    // Out-of-range write and read.
    w0 = n_wri;
    dReq = 1'b1; dWr = 1'b1; dAddr = 64'd256; dWdata = 64'hDEAD;
    wait_ack(1'b1, "t5_wr_ack", c);
    chk("t5_wr_err", 64'(err), 1);
    tick(); dWr = 1'b0; dAddr = 64'd300;
    wait_ack(1'b1, "t5_rd_ack", c);
    chk("t5_rd_err", 64'(err), 1);
    chk("t5_rd_dData", dData, 0);
    tick(); dReq = 1'b0;
    tick();
    chk("t5_no_memoryWri", 64'(n_wri - w0), 0);
    chk("t5_mem0", mem[0], 64'h0BAD);

    // Reset hits the ACCESS cycle of an in-range D write.
    d0 = n_dack; w0 = n_wri;
    dReq = 1'b1; dWr = 1'b1; dAddr = 64'd7; dWdata = 64'hBEEF;
    tick();
    reset = 1'b1; dReq = 1'b0; dWr = 1'b0;
    @(negedge clk);
    chk("t6_memoryWri_in_reset", 64'(memoryWri), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_iAck", 64'(iAck), 0);
    chk("t6_dAck", 64'(dAck), 0);
    chk("t6_err", 64'(err), 0);
    chk("t6_iData", iData, 0);
    chk("t6_dData", dData, 0);
    chk("t6_address", address, 0);
    chk("t6_memoryRead", 64'(memoryRead), 0);
    chk("t6_mem7", mem[7], 64'h7777);
    tick();
    tick();
    chk("t6_no_dack", 64'(n_dack - d0), 0);
    chk("t6_no_write", 64'(n_wri - w0), 0);

    // Randomized concurrent traffic, checked cycle by cycle by the model.
    fork
      drv_i(150);
      drv_d(150);
    join
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
